// File: rtl/poly1305_block_framer.sv
// Packs a 32-bit byte stream into 128-bit zero-padded Poly1305 blocks (AAD, payload, length).
// Optional protocol checking on err is compiled in with `define FRAMER_ERRCHK_EN.
module poly1305_block_framer #(
  parameter int LEN_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         no_aad,
  input  logic         no_pld,
  input  logic         in_valid,
  input  logic [31:0]  in_data,
  input  logic [3:0]   in_keep,
  input  logic         in_last,
  output logic         in_ready,
  output logic         aad_valid,
  output logic [127:0] aad_data,
  output logic [15:0]  aad_keep,
  input  logic         aad_ready,
  output logic         pld_valid,
  output logic [127:0] pld_data,
  output logic [15:0]  pld_keep,
  input  logic         pld_ready,
  output logic         len_valid,
  output logic [127:0] len_block,
  input  logic         len_ready,
  output logic         busy,
  output logic         done,
  output logic         err
);

  typedef enum logic [2:0] {
    IDLE, AAD_COL, AAD_EMIT, PLD_COL, PLD_EMIT, LEN_EMIT
  } state_t;

  state_t             state_q, state_d;
  logic [127:0]       buf_q, buf_d;
  logic [15:0]        keep_q, keep_d;
  logic [1:0]         idx_q, idx_d;
  logic [LEN_W-1:0]   aad_cnt_q, aad_cnt_d;
  logic [LEN_W-1:0]   pld_cnt_q, pld_cnt_d;
  logic               no_pld_q, no_pld_d;
  logic               last_q, last_d;
  logic               done_q, done_d;

  logic               in_aad;
  logic [2:0]         pop;
  logic [LEN_W-1:0]   cnt_cur, cnt_sum;
  logic [31:0]        word_masked;
  state_t             next_phase;

  function automatic logic [2:0] popcnt4(input logic [3:0] k);
    popcnt4 = 3'(k[0]) + 3'(k[1]) + 3'(k[2]) + 3'(k[3]);
  endfunction

  function automatic logic [31:0] mask_word(input logic [31:0] d, input logic [3:0] k);
    for (int b = 0; b < 4; b++) mask_word[8*b +: 8] = k[b] ? d[8*b +: 8] : 8'h00;
  endfunction

  assign in_aad      = (state_q == AAD_COL);
  assign pop         = popcnt4(in_keep);
  assign cnt_cur     = in_aad ? aad_cnt_q : pld_cnt_q;
  assign word_masked = mask_word(in_data, in_keep);
  // After AAD comes payload unless the message has none; after payload, the length block.
  assign next_phase  = (in_aad && !no_pld_q) ? PLD_COL : LEN_EMIT;

`ifdef FRAMER_ERRCHK_EN
  logic err_q, err_d;
  logic wrap;

  function automatic logic keep_legal(input logic [3:0] k);
    keep_legal = (k == 4'b0000) || (k == 4'b0001) || (k == 4'b0011) ||
                 (k == 4'b0111) || (k == 4'b1111);
  endfunction

  assign {wrap, cnt_sum} = {1'b0, cnt_cur} + (LEN_W+1)'(pop);
  assign err = err_q;
`else
  assign cnt_sum = cnt_cur + LEN_W'(pop);
  assign err     = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    keep_d    = keep_q;
    idx_d     = idx_q;
    aad_cnt_d = aad_cnt_q;
    pld_cnt_d = pld_cnt_q;
    no_pld_d  = no_pld_q;
    last_d    = last_q;
    done_d    = 1'b0;
`ifdef FRAMER_ERRCHK_EN
    err_d     = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          aad_cnt_d = '0;
          pld_cnt_d = '0;
          no_pld_d  = no_pld;
          last_d    = 1'b0;
`ifdef FRAMER_ERRCHK_EN
          err_d     = 1'b0;
`endif
          if (!no_aad)     state_d = AAD_COL;
          else if (!no_pld) state_d = PLD_COL;
          else              state_d = LEN_EMIT;
        end
      end
      AAD_COL, PLD_COL: begin
        if (in_valid) begin
          if (in_aad) aad_cnt_d = cnt_sum;
          else        pld_cnt_d = cnt_sum;
`ifdef FRAMER_ERRCHK_EN
          if (!keep_legal(in_keep) || (in_keep != 4'hF && !in_last) || wrap) err_d = 1'b1;
`endif
          // A closing word with nothing buffered ends the section without a block.
          if (in_last && idx_q == 2'd0 && in_keep == 4'h0) begin
            state_d = next_phase;
          end else begin
            buf_d[{idx_q, 5'd0} +: 32] = word_masked;
            keep_d[{idx_q, 2'd0} +: 4] = in_keep;
            idx_d  = idx_q + 2'd1;
            last_d = in_last;
            if (idx_q == 2'd3 || in_last) state_d = in_aad ? AAD_EMIT : PLD_EMIT;
          end
        end
      end
      AAD_EMIT, PLD_EMIT: begin
        if ((state_q == AAD_EMIT) ? aad_ready : pld_ready) begin
          buf_d  = '0;
          keep_d = '0;
          idx_d  = 2'd0;
          last_d = 1'b0;
          if (state_q == AAD_EMIT) state_d = last_q ? (no_pld_q ? LEN_EMIT : PLD_COL) : AAD_COL;
          else                     state_d = last_q ? LEN_EMIT : PLD_COL;
        end
      end
      LEN_EMIT: begin
        if (len_ready) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      buf_q     <= '0;
      keep_q    <= '0;
      idx_q     <= 2'd0;
      aad_cnt_q <= '0;
      pld_cnt_q <= '0;
      no_pld_q  <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef FRAMER_ERRCHK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      keep_q    <= keep_d;
      idx_q     <= idx_d;
      aad_cnt_q <= aad_cnt_d;
      pld_cnt_q <= pld_cnt_d;
      no_pld_q  <= no_pld_d;
      last_q    <= last_d;
      done_q    <= done_d;
`ifdef FRAMER_ERRCHK_EN
      err_q     <= err_d;
`endif
    end
  end

  // Outputs decode registered state only; nothing flows combinationally from inputs.
  assign in_ready  = (state_q == AAD_COL) || (state_q == PLD_COL);
  assign aad_valid = (state_q == AAD_EMIT);
  assign aad_data  = aad_valid ? buf_q : '0;
  assign aad_keep  = aad_valid ? keep_q : '0;
  assign pld_valid = (state_q == PLD_EMIT);
  assign pld_data  = pld_valid ? buf_q : '0;
  assign pld_keep  = pld_valid ? keep_q : '0;
  assign len_valid = (state_q == LEN_EMIT);
  assign len_block = len_valid ? {64'(pld_cnt_q), 64'(aad_cnt_q)} : '0;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_poly1305_block_framer.sv
// Randomized scoreboard bench for poly1305_block_framer; honours FRAMER_ERRCHK_EN if defined.
module tb_poly1305_block_framer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0, no_aad = 1'b0, no_pld = 1'b0;
  logic         in_valid = 1'b0, in_last = 1'b0;
  logic [31:0]  in_data = '0;
  logic [3:0]   in_keep = '0;
  logic         in_ready;
  logic         aad_valid, pld_valid, len_valid;
  logic [127:0] aad_data, pld_data, len_block;
  logic [15:0]  aad_keep, pld_keep;
  logic         aad_ready = 1'b0, pld_ready = 1'b0, len_ready = 1'b0;
  logic         busy, done, err;

`ifdef FRAMER_ERRCHK_EN
  localparam logic ERRCHK = 1'b1;
`else
  localparam logic ERRCHK = 1'b0;
`endif

  poly1305_block_framer #(.LEN_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .no_aad(no_aad), .no_pld(no_pld),
    .in_valid(in_valid), .in_data(in_data), .in_keep(in_keep), .in_last(in_last),
    .in_ready(in_ready),
    .aad_valid(aad_valid), .aad_data(aad_data), .aad_keep(aad_keep), .aad_ready(aad_ready),
    .pld_valid(pld_valid), .pld_data(pld_data), .pld_keep(pld_keep), .pld_ready(pld_ready),
    .len_valid(len_valid), .len_block(len_block), .len_ready(len_ready),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] d; logic [3:0] k; logic l;} word_t;
  typedef struct packed {logic [127:0] d; logic [15:0] k;} blk_t;

  word_t        aad_w[$], pld_w[$];
  blk_t         exp_aad[$], exp_pld[$];
  logic [127:0] exp_len[$];

  int n_checks = 0, n_pass = 0;
  int aad_hs_cnt = 0, pld_hs_cnt = 0, len_hs_cnt = 0, done_cnt = 0;
  logic         len_hs_prev = 1'b0, ir_seen = 1'b0, hold_pld = 1'b0;
  logic         pld_held = 1'b0;
  logic [127:0] held_d, last_aad_data, last_len;
  logic [15:0]  held_k, last_aad_keep, last_pld_keep;
  blk_t         cb;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference framing: each block takes up to four word slots, closing early on a last word;
  // a last word with no bytes and nothing pending contributes no block.
  function automatic int model_section(input bit is_aad);
    word_t w[$];
    blk_t  b;
    int    n, bytes;
    if (is_aad) w = aad_w; else w = pld_w;
    b = '0; n = 0; bytes = 0;
    foreach (w[i]) begin
      for (int j = 0; j < 4; j++) if (w[i].k[j]) bytes++;
      if (!(w[i].l && n == 0 && w[i].k == 4'h0)) begin
        for (int j = 0; j < 4; j++)
          if (w[i].k[j]) begin
            b.d[(4*n+j)*8 +: 8] = w[i].d[8*j +: 8];
            b.k[4*n+j] = 1'b1;
          end
        n++;
        if (n == 4 || w[i].l) begin
          if (is_aad) exp_aad.push_back(b); else exp_pld.push_back(b);
          b = '0; n = 0;
        end
      end
    end
    return bytes;
  endfunction

  task automatic fill(input bit is_aad, input int n, input logic [3:0] last_k);
    word_t w;
    if (is_aad) aad_w.delete(); else pld_w.delete();
    for (int i = 0; i < n; i++) begin
      w.d = $urandom;
      w.l = (i == n - 1);
      w.k = w.l ? last_k : 4'hF;
      if (is_aad) aad_w.push_back(w); else pld_w.push_back(w);
    end
  endtask

  function automatic logic [3:0] rand_last_keep();
    case ($urandom_range(0, 4))
      0: return 4'h0;
      1: return 4'h1;
      2: return 4'h3;
      3: return 4'h7;
      default: return 4'hF;
    endcase
  endfunction

  task automatic send_word(input word_t w);
    int t = 0;
    in_valid = 1'b1; in_data = w.d; in_keep = w.k; in_last = w.l;
    @(negedge clk);
    while (!in_ready && t < 300) begin @(negedge clk); t++; end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = $urandom; in_keep = 4'($urandom); in_last = 1'($urandom);
    repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
  endtask

  task automatic start_msg(input bit na, input bit np);
    int a = 0, p = 0;
    if (!na) a = model_section(1'b1);
    if (!np) p = model_section(1'b0);
    exp_len.push_back({64'(p), 64'(a)});
    @(negedge clk);
    start = 1'b1; no_aad = na; no_pld = np;
    @(posedge clk); #1;
    start = 1'b0; no_aad = 1'($urandom); no_pld = 1'($urandom);
    chk("busy_after_start", busy, 1);
  endtask

  task automatic run_msg(input bit na, input bit np, input logic exp_err);
    int hs0, t;
    hs0 = len_hs_cnt;
    start_msg(na, np);
    if (!na) foreach (aad_w[i]) send_word(aad_w[i]);
    if (!np) foreach (pld_w[i]) send_word(pld_w[i]);
    t = 0;
    while (len_hs_cnt == hs0 && t < 500) begin @(negedge clk); t++; end
    if (len_hs_cnt == hs0) chk("msg_timeout", 0, 1);
    @(negedge clk);
    chk("aad_queue_drained", exp_aad.size(), 0);
    chk("pld_queue_drained", exp_pld.size(), 0);
    chk("err_after_msg", err, exp_err);
    chk("idle_after_done", busy, 0);
  endtask

  // Consumer ready lines toggle randomly; payload can be held off for the stall test.
  initial forever begin
    @(posedge clk); #1;
    aad_ready = ($urandom_range(0, 3) != 0);
    pld_ready = hold_pld ? 1'b0 : ($urandom_range(0, 3) != 0);
    len_ready = ($urandom_range(0, 2) != 0);
  end

  always @(negedge clk) begin
    if (rst) begin
      len_hs_prev = 1'b0;
      pld_held    = 1'b0;
    end else begin
      chk("done_pulse", done, len_hs_prev);
      if (done) done_cnt++;
      if (in_ready) ir_seen = 1'b1;
      chk("in_ready_while_valid", in_ready && (aad_valid || pld_valid || len_valid), 0);
      if (pld_held) chk("pld_hold_stable", {pld_valid, pld_data, pld_keep}, {1'b1, held_d, held_k});
      pld_held = pld_valid && !pld_ready;
      held_d = pld_data; held_k = pld_keep;
      if (aad_valid && aad_ready) begin
        if (exp_aad.size() == 0) chk("aad_unexpected_block", 1, 0);
        else begin
          cb = exp_aad.pop_front();
          chk("aad_data", aad_data, cb.d);
          chk("aad_keep", aad_keep, cb.k);
        end
        last_aad_data = aad_data; last_aad_keep = aad_keep; aad_hs_cnt++;
      end
      if (pld_valid && pld_ready) begin
        if (exp_pld.size() == 0) chk("pld_unexpected_block", 1, 0);
        else begin
          cb = exp_pld.pop_front();
          chk("pld_data", pld_data, cb.d);
          chk("pld_keep", pld_keep, cb.k);
        end
        last_pld_keep = pld_keep; pld_hs_cnt++;
      end
      if (len_valid && len_ready) begin
        if (exp_len.size() == 0) chk("len_unexpected_block", 1, 0);
        else chk("len_block", len_block, exp_len.pop_front());
        last_len = len_block; len_hs_cnt++;
      end
      len_hs_prev = len_valid && len_ready;
    end
  end

  function automatic logic [511:0] all_outputs();
    return 512'({in_ready, aad_valid, aad_data, aad_keep, pld_valid, pld_data, pld_keep,
                 len_valid, len_block, busy, done, err});
  endfunction

  task automatic case1();
    int d0 = done_cnt;
    fill(1'b1, 3, 4'hF);
    fill(1'b0, 4, 4'hF);
    run_msg(1'b0, 1'b0, 1'b0);
    chk("t1_aad_keep", last_aad_keep, 16'h0FFF);
    chk("t1_aad_top_zero", last_aad_data[127:96], 0);
    chk("t1_pld_keep", last_pld_keep, 16'hFFFF);
    chk("t1_len", last_len, {64'd16, 64'd12});
    chk("t1_done_count", done_cnt, d0 + 1);
  endtask

  initial begin
    int a0, h0, t;
    word_t w;
    #3;
    chk("reset_outputs_zero", all_outputs(), 0);
    #12;
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_in_ready", in_ready, 0);

    case1();

    // No AAD: one full word then one byte.
    a0 = aad_hs_cnt;
    aad_w.delete();
    pld_w.delete();
    w.d = 32'h44332211; w.k = 4'hF; w.l = 1'b0; pld_w.push_back(w);
    w.d = 32'hDEADBE55; w.k = 4'h1; w.l = 1'b1; pld_w.push_back(w);
    run_msg(1'b1, 1'b0, 1'b0);
    chk("t2_no_aad_blocks", aad_hs_cnt, a0);
    chk("t2_pld_keep", last_pld_keep, 16'h001F);
    chk("t2_len", last_len, {64'd5, 64'd0});

    // Neither section: only the length block.
    a0 = aad_hs_cnt; h0 = pld_hs_cnt; ir_seen = 1'b0;
    run_msg(1'b1, 1'b1, 1'b0);
    chk("t3_len_zero", last_len, 128'h0);
    chk("t3_in_ready_low", ir_seen, 0);
    chk("t3_no_data_blocks", aad_hs_cnt + pld_hs_cnt, a0 + h0);

    // Payload consumer stalled for 10 cycles.
    fill(1'b1, 1, 4'h7);
    fill(1'b0, 4, 4'hF);
    h0 = pld_hs_cnt;
    hold_pld = 1'b1;
    fork
      run_msg(1'b0, 1'b0, 1'b0);
      begin
        t = 0;
        while (!pld_valid && t < 300) begin @(negedge clk); t++; end
        chk("t4_pld_valid_seen", pld_valid, 1);
        held_d = pld_data; held_k = pld_keep;
        repeat (10) begin
          @(negedge clk);
          chk("t4_stall_stable", {pld_valid, pld_data, pld_keep, in_ready}, {1'b1, held_d, held_k, 1'b0});
        end
        hold_pld = 1'b0;
      end
    join
    chk("t4_one_handshake", pld_hs_cnt, h0 + 1);

    // Non-contiguous keep on an AAD word.
    aad_w.delete();
    w.d = 32'hA1B2C3D4; w.k = 4'b0101; w.l = 1'b1; aad_w.push_back(w);
    fill(1'b0, 2, 4'h3);
    run_msg(1'b0, 1'b0, ERRCHK);
    chk("t5_len", last_len, {64'd6, 64'd2});
    repeat (3) @(negedge clk);
    chk("t5_err_sticky", err, ERRCHK);

    // Randomized messages; the first start after t5 also clears err.
    for (int m = 0; m < 25; m++) begin
      fill(1'b1, $urandom_range(1, 9), rand_last_keep());
      fill(1'b0, $urandom_range(1, 9), rand_last_keep());
      run_msg($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, 1'b0);
    end

    // Reset in the middle of the payload section.
    fill(1'b1, 3, 4'hF);
    fill(1'b0, 4, 4'hF);
    start_msg(1'b0, 1'b0);
    foreach (aad_w[i]) send_word(aad_w[i]);
    send_word(pld_w[0]);
    send_word(pld_w[1]);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("t6_reset_outputs_zero", all_outputs(), 0);
    exp_aad.delete(); exp_pld.delete(); exp_len.delete();
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("t6_post_reset_outputs", all_outputs(), 0);
    case1();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
